// File: rtl/ab_key_event.sv
// ab_key_event: turns classifier press codes into SINGLE/DOUBLE/LONG events and a wrap-around mode index.
// Latency: LONG/DOUBLE registered 1 clk after the press edge, SINGLE DBLWIN clks after its edge.
// Backpressure: none (one-clk strobe); with AB_KEY_EVT_HOLD_EN the event holds until evt_ack, later events dropped.
`timescale 1ns/1ps
module ab_key_event #(
    parameter int DBLWIN = 40,
    parameter int NMODES = 4,
    parameter int MW     = 2
) (
    input  logic          clk_100,
    input  logic          rst_n,
    input  logic [1:0]    keycode,
`ifdef AB_KEY_EVT_HOLD_EN
    input  logic          evt_ack,
`endif
    output logic          evt_valid,
    output logic [1:0]    evt_code,
    output logic [MW-1:0] mode,
    output logic          busy
);
    localparam int CW = $clog2(DBLWIN);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DBLWIN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [MW-1:0] MODE_MAX = MW'(NMODES - 1);
    localparam logic [MW-1:0] MODE_ONE = MW'(1);

    localparam logic [1:0] EVT_NONE   = 2'b00;
    localparam logic [1:0] EVT_SINGLE = 2'b01;
    localparam logic [1:0] EVT_DOUBLE = 2'b10;
    localparam logic [1:0] EVT_LONG   = 2'b11;

    typedef enum logic {IDLE, WAIT2} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    kc_prev, kc_eff;
    logic          press_s, press_l;
    logic          new_vld;
    logic [1:0]    new_code;
    logic [MW-1:0] mode_nxt;

    // Code 10 is not a valid press and behaves as released
    assign kc_eff  = (keycode == 2'b10) ? 2'b00 : keycode;
    assign press_s = (kc_eff == 2'b01) && (kc_prev == 2'b00);
    assign press_l = (kc_eff == 2'b11) && (kc_prev == 2'b00);
    assign busy    = (state == WAIT2);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        new_vld   = 1'b0;
        new_code  = EVT_NONE;
        case (state)
            IDLE: begin
                if (press_l) begin
                    new_vld  = 1'b1;
                    new_code = EVT_LONG;
                end else if (press_s) begin
                    state_nxt = WAIT2;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            WAIT2: begin
                // A press edge wins over a timeout landing in the same cycle
                if (press_s || press_l || cnt == '0) begin
                    new_vld   = 1'b1;
                    new_code  = press_s ? EVT_DOUBLE : (press_l ? EVT_LONG : EVT_SINGLE);
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
        endcase
    end

    always_comb begin
        mode_nxt = mode;
        if (new_vld) begin
            case (new_code)
                EVT_SINGLE: mode_nxt = (mode == MODE_MAX) ? '0 : mode + MODE_ONE;
                EVT_DOUBLE: mode_nxt = (mode == '0) ? MODE_MAX : mode - MODE_ONE;
                EVT_LONG:   mode_nxt = '0;
                default:    mode_nxt = mode;
            endcase
        end
    end

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            kc_prev <= 2'b00;
            mode    <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            kc_prev <= kc_eff;
            mode    <= mode_nxt;
        end
    end

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_code  <= EVT_NONE;
        end else begin
`ifdef AB_KEY_EVT_HOLD_EN
            // Mode still follows events dropped while an unacked one is pending
            if (new_vld && (!evt_valid || evt_ack)) begin
                evt_valid <= 1'b1;
                evt_code  <= new_code;
            end else if (evt_valid && evt_ack) begin
                evt_valid <= 1'b0;
                evt_code  <= EVT_NONE;
            end
`else
            evt_valid <= new_vld;
            evt_code  <= new_code;
`endif
        end
    end
endmodule

// File: tb/tb_ab_key_event.sv
// Bench for ab_key_event: table of press scenarios with a scoreboard of expected events, plus reset and hold sequences.
`timescale 1ns/1ps
module tb_ab_key_event;
    localparam int DBLWIN = 40;
    localparam int NMODES = 4;
    localparam int MW     = 2;
    localparam int NV     = 13;

    logic          clk_100 = 1'b0;
    logic          rst_n   = 1'b0;
    logic [1:0]    keycode = 2'b00;
    logic          evt_ack = 1'b1;
    logic          evt_valid;
    logic [1:0]    evt_code;
    logic [MW-1:0] mode;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b1;

    typedef struct {
        logic [1:0]    code;
        int            at;
        logic [MW-1:0] mode;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0]    kc_a;
        int            len_a;
        int            gap_b;
        logic [1:0]    kc_b;
        int            len_b;
        logic [1:0]    exp_code;
        bit            at_b;
        logic [MW-1:0] exp_mode;
    } vec_t;
    vec_t v[NV];

    ab_key_event #(.DBLWIN(DBLWIN), .NMODES(NMODES), .MW(MW)) dut (
        .clk_100   (clk_100),
        .rst_n     (rst_n),
        .keycode   (keycode),
`ifdef AB_KEY_EVT_HOLD_EN
        .evt_ack   (evt_ack),
`endif
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .mode      (mode),
        .busy      (busy)
    );

    always #5 clk_100 = ~clk_100;
    always @(posedge clk_100) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input logic [1:0] kc);
        keycode = kc;
        @(posedge clk_100);
        #1;
    endtask

    // Scoreboard: every observed event must match the oldest expected one
    always @(negedge clk_100) begin
        exp_t e;
        if (rst_n && mon_en && evt_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: code %b at cycle %0d, none expected", evt_code, cyc);
            end else begin
                e = sb.pop_front();
                chk("evt_code", int'(evt_code), int'(e.code));
                chk("evt_cycle", cyc, e.at);
                chk("evt_mode", int'(mode), int'(e.mode));
            end
        end
    end

    initial begin
        int ea, n, off;
        logic [1:0] k;

        v[0]  = '{2'b01,  2, 10, 2'b01, 2, 2'b10, 1'b1, 2'd3}; // double 0->3
        v[1]  = '{2'b01,  2,  0, 2'b00, 0, 2'b01, 1'b0, 2'd0}; // single wraps 3->0
        v[2]  = '{2'b01,  2,  0, 2'b00, 0, 2'b01, 1'b0, 2'd1};
        v[3]  = '{2'b01,  2,  0, 2'b00, 0, 2'b01, 1'b0, 2'd2};
        v[4]  = '{2'b01,  2,  5, 2'b11, 3, 2'b11, 1'b1, 2'd0}; // long inside window
        v[5]  = '{2'b01,  2, 40, 2'b01, 2, 2'b10, 1'b1, 2'd3}; // second press at cnt==0
        v[6]  = '{2'b11,  3,  0, 2'b00, 0, 2'b11, 1'b1, 2'd0}; // long from idle
        v[7]  = '{2'b01, 30, 30, 2'b11, 5, 2'b01, 1'b0, 2'd1}; // held 01 then 01->11
        v[8]  = '{2'b01,  2,  0, 2'b00, 0, 2'b01, 1'b0, 2'd2};
        v[9]  = '{2'b01,  2,  0, 2'b00, 0, 2'b01, 1'b0, 2'd3};
        v[10] = '{2'b01,  2,  0, 2'b00, 0, 2'b01, 1'b0, 2'd0};
        v[11] = '{2'b01,  2,  0, 2'b00, 0, 2'b01, 1'b0, 2'd1};
        v[12] = '{2'b10,  3,  3, 2'b01, 2, 2'b01, 1'b1, 2'd2}; // 10 acts as released

        tick(2'b00);
        tick(2'b00);
        chk("rst_evt_valid", int'(evt_valid), 0);
        chk("rst_evt_code", int'(evt_code), 0);
        chk("rst_mode", int'(mode), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick(2'b00);
        tick(2'b00);

        for (int i = 0; i < NV; i++) begin
            ea = cyc + 1;
            if (v[i].exp_code != 2'b00) begin
                off = (v[i].at_b ? v[i].gap_b : 0) + ((v[i].exp_code == 2'b01) ? DBLWIN : 0);
                sb.push_back('{v[i].exp_code, ea + off, v[i].exp_mode});
            end
            n = ((v[i].gap_b + v[i].len_b > v[i].len_a) ? v[i].gap_b + v[i].len_b : v[i].len_a) + DBLWIN + 4;
            for (int t = 0; t < n; t++) begin
                k = 2'b00;
                if (t < v[i].len_a) k = v[i].kc_a;
                if (v[i].len_b > 0 && t >= v[i].gap_b && t < v[i].gap_b + v[i].len_b) k = v[i].kc_b;
                tick(k);
                if (t == 0 && v[i].kc_a == 2'b01) chk("busy_after_edge", int'(busy), 1);
            end
            if (sb.size() != 0) $display("FAIL missed_event: vector %0d left %0d expected events", i, sb.size());
            chk("sb_drained", sb.size(), 0);
            sb.delete();
            chk("mode_end", int'(mode), int'(v[i].exp_mode));
            chk("busy_end", int'(busy), 0);
        end

        // Asynchronous reset while a short press is pending
        tick(2'b01);
        tick(2'b01);
        repeat (3) tick(2'b00);
        chk("busy_before_reset", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(evt_valid), 0);
        chk("async_rst_code", int'(evt_code), 0);
        chk("async_rst_mode", int'(mode), 0);
        chk("async_rst_busy", int'(busy), 0);
        tick(2'b00);
        tick(2'b00);
        rst_n = 1'b1;
        repeat (DBLWIN + 10) tick(2'b00);
        chk("post_reset_mode", int'(mode), 0);
        chk("post_reset_busy", int'(busy), 0);

`ifdef AB_KEY_EVT_HOLD_EN
        mon_en  = 1'b0;
        evt_ack = 1'b0;
        tick(2'b01);
        repeat (DBLWIN) tick(2'b00);
        chk("hold_first_valid", int'(evt_valid), 1);
        chk("hold_first_code", int'(evt_code), 1);
        chk("hold_first_mode", int'(mode), 1);
        for (int t = 0; t < 20; t++) begin
            tick(2'b00);
            chk("hold_valid", int'(evt_valid), 1);
            chk("hold_code", int'(evt_code), 1);
        end
        tick(2'b11);
        chk("hold_drop_code", int'(evt_code), 1);
        chk("hold_drop_mode", int'(mode), 0);
        tick(2'b00);
        evt_ack = 1'b1;
        tick(2'b00);
        chk("hold_ack_valid", int'(evt_valid), 0);
        chk("hold_ack_code", int'(evt_code), 0);
        mon_en = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ab_key_event.md
Name: ab_key_event

Overview:
- Downstream consumer of the debounced key classifier.
- Takes its 2-bit press code (00 none, 01 short, 11 long) and turns it into discrete user events: SINGLE, DOUBLE or LONG.
- Maintains a wrap-around mode index driven by those events.
- Runs in the same 10 ms tick domain (clk_100); feeds menu/mode logic.

Parameters:
- DBLWIN, 40, double-click window in clk_100 ticks (10 ms units), must be >=2.
- NMODES, 4, number of mode values, 2..2^MW.
- MW, 2, width of mode output.

Ports:
- clk_100  input  1  10 ms tick clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- keycode  input  2  press code from key classifier: 00 none, 01 short, 11 long; 10 treated as 00
- evt_valid  output  1  event strobe (see Optional Feature for hold mode)
- evt_code  output  2  01 SINGLE, 10 DOUBLE, 11 LONG, 00 when no event
- mode  output  MW  current mode index, 0..NMODES-1
- busy  output  1  high while a short press awaits a possible second press (WAIT2)

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0, all outputs are 0, FSM is IDLE, window counter is 0 and keycode history is 00. Reset mid-window discards the pending short with no event.
- Edge detect:
  - kc_prev is registered keycode (10 mapped to 00).
  - press_s = (keycode==01 && kc_prev==00).
  - press_l = (keycode==11 && kc_prev==00).
  - A held nonzero code produces exactly one edge.
  - A direct 01->11 or 11->01 transition is not an edge.
- FSM states: IDLE, WAIT2.
  - IDLE, press_l: emit LONG; stay IDLE.
  - IDLE, press_s: go to WAIT2; cnt<=DBLWIN-1; busy<=1.
  - WAIT2, press_s: emit DOUBLE; go to IDLE.
  - WAIT2, press_l: emit LONG only; the pending short is discarded; go to IDLE.
  - WAIT2, no edge, cnt==0: emit SINGLE; go to IDLE.
  - WAIT2, no edge, cnt>0: cnt<=cnt-1.
  - In WAIT2 an edge has priority over timeout in the same cycle.
- Latency:
  - LONG and DOUBLE: evt_valid rises in the cycle after the first cycle keycode shows the new nonzero code (1 clk).
  - SINGLE: evt_valid rises exactly DBLWIN clks after its edge cycle.
- Strobe (macro off): evt_valid=1 for exactly one clk with evt_code valid; evt_code=00 otherwise.
- Mode update happens in the same clock that registers the event:
  - SINGLE: mode+1, wrapping from NMODES-1 to 0.
  - DOUBLE: mode-1, wrapping from 0 to NMODES-1.
  - LONG: mode<=0.
- cnt width is clog2(DBLWIN); no overflow is possible because cnt only loads DBLWIN-1 and decrements to 0.

Optional Feature:
- Macro name: AB_KEY_EVT_HOLD_EN.
- Defined:
  - Adds input evt_ack (1 bit).
  - evt_valid/evt_code are held until a cycle with evt_valid&&evt_ack; they clear on the next clk.
  - Events generated while evt_valid=1 and not acked in that cycle are dropped from the output, but mode still updates.
  - An ack and a new event in the same cycle load the new event (evt_valid stays 1).
- Undefined: there is no evt_ack port and the one-clk strobe behaviour applies.

Test Plan:
- Reset: rst_n=0 asynchronously mid-WAIT2 (DBLWIN=40) -> outputs 0 immediately; no SINGLE after release; mode=0.
- Single: keycode 00->01 held 2 clks then 00 -> busy=1; evt_valid=1, evt_code=01 exactly 40 clks after the edge cycle; mode 0->1.
- Double: 01 pulse, then a second 01 edge 10 clks later -> one DOUBLE (10), no SINGLE; mode 0->3 (NMODES=4).
- Long in window: 01 edge, then 11 edge 5 clks later -> one LONG (11) 1 clk after the edge, no SINGLE; mode from 2->0.
- Boundary: second 01 edge in the cycle cnt==0 -> DOUBLE, not SINGLE. Also, four SINGLEs from mode 0 -> mode sequence 1,2,3,0. Also, a held 01 for 30 clks and a 01->11 transition -> no extra edges.
- Macro on: event with evt_ack=0 for 20 clks -> evt_valid held with code stable; a LONG arriving meanwhile is dropped while mode still becomes 0; ack -> evt_valid=0 next clk.
